// File: rtl/rv32i_mem_arbiter_pkg.sv
// rv32i_arb_pkg: shared types and defaults for the IF/MEM memory arbiter
package rv32i_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
  localparam int MEM_LAT_DEF = 1;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// rv32i_mem_arbiter_if: fetch, data and memory-macro signals around the arbiter
interface rv32i_mem_arbiter_if
  import rv32i_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              fl;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, fl, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, fl, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: data-priority arbiter sharing one fixed-latency memory between fetch and MEM stage
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic clk,
  input logic RN,
  rv32i_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t        state;
  arb_owner_t        owner;
  logic [1:0]        cnt;
  logic [SW-1:0]     starve_cnt;
  logic              kill;
  logic              st_we;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              idle;
  logic              resp;
  logic              if_win;
  logic              dm_win;
  always_comb begin
    idle   = state == ARB_IDLE && !RN;
    resp   = state == ARB_RESP && !RN;
    if_win = idle && bus.if_req && (!bus.dm_req || starve_cnt == SW'(STARVE_MAX));
    dm_win = idle && bus.dm_req && !if_win;
  end
  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.mem_en    = if_win | dm_win;
  assign bus.mem_we    = dm_win & bus.dm_we;
  assign bus.mem_addr  = dm_win ? bus.dm_addr : if_win ? bus.if_addr : '0;
  assign bus.mem_wdata = dm_win ? bus.dm_wdata : '0;
  // a flush landing in the response cycle itself must still suppress that pulse
  assign bus.if_rvalid = resp && owner == OWN_IF && !kill && !bus.fl;
  assign bus.dm_rvalid = resp && owner == OWN_DM;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_rdata  = dm_rdata;
  always_ff @(posedge clk) begin
    if (RN) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      starve_cnt <= '0;
      kill       <= 1'b0;
      st_we      <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (if_win || dm_win) begin
          owner      <= if_win ? OWN_IF : OWN_DM;
          st_we      <= dm_win & bus.dm_we;
          cnt        <= 2'(MEM_LAT - 1);
          kill       <= if_win & bus.fl;
          starve_cnt <= if_win ? '0 :
                        (bus.if_req && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
          state      <= ARB_BUSY;
        end
        ARB_BUSY: begin
          kill <= kill | (owner == OWN_IF && bus.fl);
          if (cnt == 2'd0) begin
            if (owner == OWN_IF) if_rdata <= bus.mem_rdata;
            else dm_rdata <= st_we ? '0 : bus.mem_rdata;
            state <= ARB_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ARB_RESP: begin
          kill  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed checks on a MEM_LAT=1 and a MEM_LAT=3 arbiter with behavioural memories
module tb_rv32i_mem_arbiter;
  import rv32i_arb_pkg::*;
  logic clk;
  logic RN;
  int checks = 0;
  int errors = 0;
  rv32i_mem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) b1 ();
  rv32i_mem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) b3 ();
  rv32i_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .RN(RN), .bus(b1)
  );
  rv32i_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .RN(RN), .bus(b3)
  );
  logic [31:0] m1 [32];
  logic [31:0] r1;
  logic [31:0] m3 [32];
  logic [31:0] q3 [3];
  always @(posedge clk) begin
    if (RN) begin
      for (int i = 0; i < 32; i++) m1[i] <= 32'h100 + 32'(i);
    end else if (b1.mem_en) begin
      if (b1.mem_we) m1[b1.mem_addr] <= b1.mem_wdata;
      r1 <= m1[b1.mem_addr];
    end
  end
  assign b1.mem_rdata = r1;
  always @(posedge clk) begin
    if (RN) begin
      for (int i = 0; i < 32; i++) m3[i] <= 32'h100 + 32'(i);
    end else if (b3.mem_en && b3.mem_we) begin
      m3[b3.mem_addr] <= b3.mem_wdata;
    end
    q3[0] <= m3[b3.mem_addr];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign b3.mem_rdata = q3[2];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  initial begin
    {b1.if_req, b1.fl, b1.dm_req, b1.dm_we} = '0;
    {b3.if_req, b3.fl, b3.dm_req, b3.dm_we} = '0;
    b1.if_addr = '0; b1.dm_addr = '0; b1.dm_wdata = '0;
    b3.if_addr = '0; b3.dm_addr = '0; b3.dm_wdata = '0;
    RN = 1;
    b1.if_req = 1; b1.if_addr = 5'd5;
    smp();
    chk("rst_if_gnt", b1.if_gnt, 0);
    chk("rst_mem_en", b1.mem_en, 0);
    step();
    smp();
    chk("rst_if_gnt2", b1.if_gnt, 0);
    chk("rst_outs", {b1.mem_en, b1.mem_we, b1.dm_gnt, b1.if_rvalid, b1.dm_rvalid}, 0);
    chk("rst_mem_addr", b1.mem_addr, 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    chk("rst_dm_rdata", b1.dm_rdata, 0);
    step();
    RN = 0;
    smp();
    chk("fetch_gnt_T", b1.if_gnt, 1);
    chk("fetch_mem_en_T", b1.mem_en, 1);
    chk("fetch_mem_addr_T", b1.mem_addr, 5);
    chk("fetch_mem_we_T", b1.mem_we, 0);
    step();
    b1.if_addr = 5'd6;
    smp();
    chk("fetch_busy_gnt", b1.if_gnt, 0);
    chk("fetch_busy_rvalid", b1.if_rvalid, 0);
    step();
    smp();
    chk("fetch_resp_gnt", b1.if_gnt, 0);
    chk("fetch_rvalid_T2", b1.if_rvalid, 1);
    chk("fetch_rdata_T2", b1.if_rdata, 32'h105);
    step();
    smp();
    chk("fetch_regnt_T3", b1.if_gnt, 1);
    chk("fetch_regnt_addr", b1.mem_addr, 6);
    step();
    b1.if_req = 0;
    step();
    smp();
    chk("fetch2_rvalid", b1.if_rvalid, 1);
    chk("fetch2_rdata", b1.if_rdata, 32'h106);
    step();
    b1.if_req = 1; b1.if_addr = 5'd9;
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 5'd2;
    smp();
    chk("conf_dm_gnt", b1.dm_gnt, 1);
    chk("conf_if_gnt", b1.if_gnt, 0);
    chk("conf_mem_addr", b1.mem_addr, 2);
    step();
    b1.dm_req = 0;
    step();
    smp();
    chk("conf_dm_rvalid", b1.dm_rvalid, 1);
    chk("conf_dm_rdata", b1.dm_rdata, 32'h102);
    chk("conf_if_rvalid", b1.if_rvalid, 0);
    step();
    smp();
    chk("conf_if_gnt_next", b1.if_gnt, 1);
    chk("conf_if_addr_next", b1.mem_addr, 9);
    step();
    b1.if_req = 0;
    step();
    smp();
    chk("conf_if_rdata", b1.if_rdata, 32'h109);
    step();
    b1.if_req = 1; b1.if_addr = 5'd4;
    b1.dm_req = 1; b1.dm_addr = 5'd3;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk($sformatf("starve_dm_gnt%0d", k), b1.dm_gnt, (k != 4) ? 1 : 0);
      chk($sformatf("starve_if_gnt%0d", k), b1.if_gnt, (k == 4) ? 1 : 0);
      step();
      step();
      smp();
      if (k == 4) chk("starve_if_rdata", b1.if_rdata, 32'h104);
      else chk($sformatf("starve_dm_rdata%0d", k), b1.dm_rdata, 32'h103);
      step();
    end
    b1.if_req = 0; b1.dm_req = 0;
    step();
    b1.dm_req = 1; b1.dm_we = 1; b1.dm_addr = 5'd7; b1.dm_wdata = 32'hDEAD;
    smp();
    chk("st_gnt", b1.dm_gnt, 1);
    chk("st_mem_we", b1.mem_we, 1);
    chk("st_mem_wdata", b1.mem_wdata, 32'hDEAD);
    step();
    b1.dm_req = 0; b1.dm_we = 0;
    step();
    smp();
    chk("st_rvalid", b1.dm_rvalid, 1);
    chk("st_rdata", b1.dm_rdata, 0);
    step();
    b1.dm_req = 1; b1.dm_addr = 5'd7;
    smp();
    chk("ld_gnt", b1.dm_gnt, 1);
    chk("ld_mem_we", b1.mem_we, 0);
    step();
    b1.dm_req = 0;
    step();
    smp();
    chk("ld_rvalid", b1.dm_rvalid, 1);
    chk("ld_rdata", b1.dm_rdata, 32'hDEAD);
    step();
    b3.if_req = 1; b3.if_addr = 5'd10;
    smp();
    chk("fl_gnt", b3.if_gnt, 1);
    step();
    b3.if_req = 0; b3.fl = 1;
    smp();
    chk("fl_rvalid1", b3.if_rvalid, 0);
    step();
    b3.fl = 0;
    for (int k = 2; k <= 4; k++) begin
      smp();
      chk($sformatf("fl_rvalid%0d", k), b3.if_rvalid, 0);
      chk($sformatf("fl_gnt%0d", k), b3.if_gnt, 0);
      step();
    end
    b3.if_req = 1; b3.if_addr = 5'd11;
    smp();
    chk("fl_idle_T5", b3.if_gnt, 1);
    step();
    b3.if_req = 0;
    step();
    step();
    smp();
    chk("fl_next_early", b3.if_rvalid, 0);
    step();
    smp();
    chk("fl_next_rvalid", b3.if_rvalid, 1);
    chk("fl_next_rdata", b3.if_rdata, 32'h10B);
    step();
    b3.if_req = 1; b3.if_addr = 5'd12; b3.fl = 1;
    smp();
    chk("flg_gnt", b3.if_gnt, 1);
    step();
    b3.if_req = 0; b3.fl = 0;
    step();
    step();
    step();
    smp();
    chk("flg_rvalid", b3.if_rvalid, 0);
    step();
    b3.dm_req = 1; b3.dm_addr = 5'd1; b3.fl = 1;
    smp();
    chk("fldm_gnt", b3.dm_gnt, 1);
    step();
    b3.dm_req = 0;
    step();
    step();
    step();
    smp();
    chk("fldm_rvalid", b3.dm_rvalid, 1);
    chk("fldm_rdata", b3.dm_rdata, 32'h101);
    step();
    b3.fl = 0;
    b1.if_req = 1; b1.if_addr = 5'd0;
    smp();
    chk("rmid_gnt", b1.if_gnt, 1);
    step();
    b1.if_req = 0;
    step();
    RN = 1;
    smp();
    chk("rmid_rvalid", b1.if_rvalid, 0);
    step();
    RN = 0;
    smp();
    chk("rmid_rdata", b1.if_rdata, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

- Shares one single-port, fixed-latency 32×32 memory between the RV32I pipeline's instruction-fetch port and its memory-stage data port.
- Sits between the IF and MEM stages and the memory macro.
- Grants one access at a time; the data port has priority, with a starvation guard for fetch.
- Supports flushing an in-flight fetch response on a taken branch.

## Interface
- `ADDR_W`, 5: word address width (32 words).
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: memory read latency in cycles, legal 1..4.
- `STARVE_MAX`, 4: number of consecutive fetch losses after which fetch wins the next arbitration.

- `clk` in 1: single clock; all state updates on posedge.
- `RN` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` until `if_gnt`.
- `if_addr` in ADDR_W: fetch word address.
- `if_gnt` out 1: fetch accepted (one-cycle pulse).
- `if_rvalid` out 1: fetch data valid (one-cycle pulse).
- `if_rdata` out DATA_W: fetch data.
- `fl` in 1: flush; kills the response of any in-flight fetch.
- `dm_req` in 1: data request; held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_gnt`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in ADDR_W: data word address.
- `dm_wdata` in DATA_W: store data.
- `dm_gnt` out 1: data accepted (one-cycle pulse).
- `dm_rvalid` out 1: load data or store completion (one-cycle pulse).
- `dm_rdata` out DATA_W: load data; 0 for stores.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid MEM_LAT cycles after `mem_en`.

## Operation
- **FSM states:**
  - IDLE: arbitrate.
  - BUSY: wait for memory.
  - RESP: present the result.
- **IDLE:**
  - No request: remain in IDLE.
  - Otherwise pick an owner:
    - Fetch wins if only `if_req` is high, or if both requests are high and `starve_cnt == STARVE_MAX`.
    - Otherwise data wins.
  - Winner's `gnt` = 1; `mem_en` = 1.
  - `mem_addr`, `mem_we`, `mem_wdata` are driven from the winner's inputs in the same cycle (`mem_we` = 0 for fetch).
  - Latch the owner, set `cnt = MEM_LAT-1`, go to BUSY.
- **BUSY:**
  - If `cnt == 0`: register `mem_rdata` into the owner's rdata register (0 if the access was a store), go to RESP.
  - Else decrement `cnt`.
- **RESP:**
  - Owner's `rvalid` = 1 for one cycle.
  - Exception: an IF-owned response that was killed by `fl` asserts nothing.
  - Go to IDLE.
  - No grant is issued in BUSY or RESP.
- **`starve_cnt`:**
  - Increments, saturating at STARVE_MAX, on each IDLE grant to data while `if_req` = 1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- **`fl`:**
  - Sets a kill flag if asserted while the owner is IF in BUSY or RESP, or in the same cycle as `if_gnt`.
  - The kill flag clears on return to IDLE.
  - Has no effect on data transactions.
  - Does not abort the memory access.
- **`rdata` registers:** hold their value until the next response for that port overwrites them.
- **Addresses:** word addresses; no alignment logic. Address wraps naturally at ADDR_W bits.

## Timing
- **Grant latency:** `gnt` and `mem_en` are combinational in IDLE (Mealy). Both are forced 0 while `RN` = 1.
- **Grant at cycle T:**
  - T+1..T+MEM_LAT: BUSY.
  - T+MEM_LAT+1: `rvalid`.
  - T+MEM_LAT+2: next grant possible.
  - Access period is MEM_LAT+2 cycles.
- **Reset:** while `RN` = 1 at a posedge:
  - state = IDLE; `cnt`, `starve_cnt`, kill flag, owner = 0.
  - `if_rdata` and `dm_rdata` = 0; all `gnt`, `rvalid`, and `mem_*` outputs = 0.
- **Reset mid-transaction:** the pending response is dropped (no `rvalid`). A store already strobed into memory is not undone.
- **Simultaneous events:**
  - `fl` and `if_gnt` in the same cycle: the fetch is granted and its response is killed.
  - `fl` during a data transaction: ignored.
  - `fl` in the RESP cycle of an IF transaction: `if_rvalid` suppressed in that cycle.

## Structure
- Package `rv32i_arb_pkg` holds:
  - state enum `ARB_IDLE`/`ARB_BUSY`/`ARB_RESP`;
  - owner enum `OWN_IF`/`OWN_DM`;
  - default MEM_LAT and STARVE_MAX constants.
- Single module; no sub-module is required.
- The bench provides a behavioural memory model with MEM_LAT-cycle read latency, initialised with `mem[i] = 32'h100 + i`.

## Test plan
- **Reset:** `RN` = 1 for 2 cycles with `if_req` = 1 → all outputs 0, no grant. `RN` falls → `if_gnt` in the first cycle after reset.
- **Single fetch, MEM_LAT=1:** `if_req` with `if_addr` = 5 at T → `if_gnt` at T; `if_rvalid` at T+2 with `if_rdata` = 32'h105; next grant possible at T+3.
- **Conflict:** both requests held, `dm_addr` = 2 load → `dm_gnt` first; `dm_rvalid` with 32'h102; `if_gnt` at the next IDLE.
- **Starvation, STARVE_MAX=4:** `dm_req` and `if_req` held continuously → 4 `dm_gnt` pulses, then `if_gnt`, then data resumes.
- **Store then load:** `dm_we` = 1, `dm_addr` = 7, `dm_wdata` = 32'hDEAD → `dm_rvalid` with `dm_rdata` = 0. A subsequent load from 7 returns 32'hDEAD.
- **Flush:** `fl` = 1 one cycle after `if_gnt` (MEM_LAT=3) → no `if_rvalid` for that fetch; FSM is back in IDLE at T+5 and the next fetch completes normally.
